fifo_param: RTL

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable read mode (registered-output or first-word-fall-through). It is the generic buffer placed between the serial/parallel data paths of the design. It replaces the fixed push/pop FIFO used so far, and the existing push/pop bench style applies unchanged.

---
 rtl/fifo_param_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/fifo_param.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_param_pkg.sv
// Shared constants and types for the parametrised FIFO: default geometry,
// read-mode selectors and the per-edge operation encoding.
package fifo_param_pkg;

    localparam int FIFO_DEFAULT_DATA_WIDTH    = 10;
    localparam int FIFO_DEFAULT_ADDRESS_WIDTH = 3;

    localparam bit FIFO_MODE_REG  = 1'b0;
    localparam bit FIFO_MODE_FWFT = 1'b1;

    // Encoding is {pop accepted, push accepted}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t decode_op(input logic push_ok, input logic pop_ok);
        return fifo_op_t'({pop_ok, push_ok});
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_param: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
    import fifo_param_pkg::*;
#(
    parameter int data_width    = FIFO_DEFAULT_DATA_WIDTH,
    parameter int address_width = FIFO_DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [address_width-1:0] write_addr,
    input  logic [data_width-1:0]    write_data,
    input  logic [address_width-1:0] read_addr,
    output logic [data_width-1:0]    read_data
);

    logic [data_width-1:0] mem [2**address_width];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags,
// sticky error flags and registered or first-word-fall-through read mode.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int data_width    = FIFO_DEFAULT_DATA_WIDTH,
    parameter int address_width = FIFO_DEFAULT_ADDRESS_WIDTH,
    parameter bit FWFT          = FIFO_MODE_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [data_width-1:0]    FIFO_data_in,
    input  logic [address_width:0]   almost_full_th,
    input  logic [address_width:0]   almost_empty_th,
    output logic [data_width-1:0]    FIFO_data_out,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [address_width:0]   count,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int depth = 2**address_width;
    localparam logic [address_width:0] depth_count = (address_width+1)'(depth);

    logic [address_width-1:0] wr_ptr;
    logic [address_width-1:0] rd_ptr;
    logic [address_width:0]   count_q;
    logic                     overflow_q;
    logic                     underflow_q;
    logic [data_width-1:0]    read_data;
    logic                     push_ok;
    logic                     pop_ok;
    fifo_op_t                 op;

    assign full         = (count_q == depth_count);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= almost_full_th);
    assign almost_empty = (count_q <= almost_empty_th);
    assign count        = count_q;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign op      = decode_op(push_ok, pop_ok);

    fifo_mem #(
        .data_width    (data_width),
        .address_width (address_width)
    ) u_mem (
        .clk        (clk),
        .write_en   (push_ok),
        .write_addr (wr_ptr),
        .write_data (FIFO_data_in),
        .read_addr  (rd_ptr),
        .read_data  (read_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: count_q <= count_q + 1'b1;
                OP_POP:  count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && full && !pop_ok) begin
                overflow_q <= 1'b1;
            end
            if (pop && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Gate the array output so an empty FIFO shows zero, not stale data
            assign FIFO_data_out = empty ? '0 : read_data;
            assign valid         = ~empty;
        end else begin : g_reg
            logic [data_width-1:0] data_q;
            logic                  valid_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (pop_ok) begin
                    data_q  <= read_data;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign FIFO_data_out = data_q;
            assign valid         = valid_q;
        end
    endgenerate

endmodule
